// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised RS232 receiver with majority voting, parity, framing and break handling
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 RX_Pin_In,
   input  logic                 RX_En_Sig,
   output logic [DATA_BITS-1:0] RX_Data,
   output logic                 RX_Done_Sig,
   output logic                 Parity_Err,
   output logic                 Frame_Err,
   output logic                 RX_Busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] CNT_MAJ  = CW'(CLKS_PER_BIT / 2 + 1);
   localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_BREAK
   } state_t;

   state_t               state, state_n;
   logic                 rx_meta, rx_s, rx_s_d;
   logic [CW-1:0]        cnt;
   logic [3:0]           bit_idx;
   logic                 samp_a, samp_b;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr, ferr;
   logic                 fall, at_wrap, at_maj, maj, par_x;

   assign fall    = rx_s_d & ~rx_s;
   assign at_wrap = (cnt == CNT_LAST);
   assign at_maj  = (cnt == CNT_MAJ);
   // third vote is the live sample taken at MID+1
   assign maj     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
   assign par_x   = (^shreg) ^ maj;
   assign RX_Busy = (state != S_IDLE);

   // two-flop synchroniser plus one delayed copy for falling-edge detection
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_s_d  <= 1'b1;
      end else begin
         rx_meta <= RX_Pin_In;
         rx_s    <= rx_meta;
         rx_s_d  <= rx_s;
      end
   end

   // state register
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state <= S_IDLE;
      else       state <= state_n;
   end

   // next-state logic; stop leaves at the vote point so a following start edge is not missed
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   if (RX_En_Sig && fall) state_n = S_START;
         S_START: begin
            if (at_maj && maj)  state_n = S_IDLE;
            else if (at_wrap)   state_n = S_DATA;
         end
         S_DATA:   if (at_wrap && bit_idx == LAST_DATA)
                      state_n = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (at_wrap) state_n = S_STOP;
         S_STOP:   if (at_maj && bit_idx == LAST_STOP) state_n = S_DONE;
         S_DONE:   state_n = rx_s ? S_IDLE : S_BREAK;
         S_BREAK:  if (rx_s) state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   // bit timing, vote sampling, shift register, error flags and output registers
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cnt         <= '0;
         bit_idx     <= '0;
         samp_a      <= 1'b1;
         samp_b      <= 1'b1;
         shreg       <= '0;
         perr        <= 1'b0;
         ferr        <= 1'b0;
         RX_Data     <= '0;
         RX_Done_Sig <= 1'b0;
         Parity_Err  <= 1'b0;
         Frame_Err   <= 1'b0;
      end else begin
         RX_Done_Sig <= 1'b0;
         if (cnt == CNT_PRE) samp_a <= rx_s;
         if (cnt == CNT_MID) samp_b <= rx_s;
         case (state)
            S_START, S_DATA, S_PARITY, S_STOP: cnt <= at_wrap ? '0 : cnt + CW'(1);
            default:                            cnt <= '0;
         endcase
         case (state)
            S_IDLE: begin
               bit_idx <= '0;
               perr    <= 1'b0;
               ferr    <= 1'b0;
            end
            S_DATA: begin
               if (at_maj)  shreg   <= {maj, shreg[DATA_BITS-1:1]};
               if (at_wrap) bit_idx <= (bit_idx == LAST_DATA) ? 4'd0 : bit_idx + 4'd1;
            end
            S_PARITY: begin
               if (at_maj) perr <= (PARITY == 1) ? ~par_x : par_x;
            end
            S_STOP: begin
               if (at_wrap) bit_idx <= bit_idx + 4'd1;
               if (at_maj) begin
                  if (!maj) ferr <= 1'b1;
                  if (bit_idx == LAST_STOP) begin
                     RX_Done_Sig <= 1'b1;
                     RX_Data     <= shreg;
                     Parity_Err  <= (PARITY == 0) ? 1'b0 : perr;
                     Frame_Err   <= ferr | ~maj;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param in 8N1, 8E1 and 7O2 configurations
module tb_uart_rx_param;
   localparam int C = 16;

   typedef struct {
      logic [8:0] data;
      logic       perr;
      logic       ferr;
      int         cyc;
   } rec_t;

   logic CLK = 1'b0;
   logic RSTn = 1'b0;
   logic en = 1'b1;
   logic pin0 = 1'b1, pin1 = 1'b1, pin2 = 1'b1;
   logic [7:0] data0, data1;
   logic [6:0] data2;
   logic done0, done1, done2, perr0, perr1, perr2, ferr0, ferr1, ferr2, busy0, busy1, busy2;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   rd [3] = '{0, 0, 0};
   rec_t exp0[$], exp1[$], exp2[$];
   rec_t obs0[$], obs1[$], obs2[$];

   always #5 CLK = ~CLK;

   // cycle stamp for latency measurement
   always @(posedge CLK) cyc <= cyc + 1;

   uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
      .CLK(CLK), .RSTn(RSTn), .RX_Pin_In(pin0), .RX_En_Sig(en), .RX_Data(data0),
      .RX_Done_Sig(done0), .Parity_Err(perr0), .Frame_Err(ferr0), .RX_Busy(busy0));
   uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
      .CLK(CLK), .RSTn(RSTn), .RX_Pin_In(pin1), .RX_En_Sig(en), .RX_Data(data1),
      .RX_Done_Sig(done1), .Parity_Err(perr1), .Frame_Err(ferr1), .RX_Busy(busy1));
   uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut2 (
      .CLK(CLK), .RSTn(RSTn), .RX_Pin_In(pin2), .RX_En_Sig(en), .RX_Data(data2),
      .RX_Done_Sig(done2), .Parity_Err(perr2), .Frame_Err(ferr2), .RX_Busy(busy2));

   // capture every Done pulse of every receiver
   always @(negedge CLK) begin
      if (done0) obs0.push_back('{data: {1'b0, data0}, perr: perr0, ferr: ferr0, cyc: cyc});
      if (done1) obs1.push_back('{data: {1'b0, data1}, perr: perr1, ferr: ferr1, cyc: cyc});
      if (done2) obs2.push_back('{data: {2'b0, data2}, perr: perr2, ferr: ferr2, cyc: cyc});
   end

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic int obs_size(input int w);
      case (w)
         0:       return obs0.size();
         1:       return obs1.size();
         default: return obs2.size();
      endcase
   endfunction

   function automatic logic good_par(input logic [8:0] d, input int nb, input int par);
      logic x = 1'b0;
      for (int i = 0; i < nb; i++) x ^= d[i];
      return (par == 1) ? ~x : x;
   endfunction

   task automatic push_exp(input int w, input logic [8:0] d, input int nb, input int par,
                           input logic pbit, input logic fe);
      rec_t r;
      logic x = 1'b0;
      for (int i = 0; i < nb; i++) x ^= d[i];
      r.data = d;
      r.perr = (par == 0) ? 1'b0 : (par == 1) ? ~(x ^ pbit) : (x ^ pbit);
      r.ferr = fe;
      r.cyc  = 0;
      case (w)
         0:       exp0.push_back(r);
         1:       exp1.push_back(r);
         default: exp2.push_back(r);
      endcase
   endtask

   task automatic set_pin(input int w, input logic v);
      case (w)
         0:       pin0 = v;
         1:       pin1 = v;
         default: pin2 = v;
      endcase
   endtask

   task automatic hold(input int w, input logic v, input int n);
      set_pin(w, v);
      repeat (n) @(negedge CLK);
   endtask

   task automatic send_frame(input int w, input logic [8:0] d, input int nb, input int par,
                             input logic pbit, input int sb);
      hold(w, 1'b0, C);
      for (int i = 0; i < nb; i++) hold(w, d[i], C);
      if (par != 0) hold(w, pbit, C);
      for (int i = 0; i < sb; i++) hold(w, 1'b1, C);
   endtask

   task automatic check_out(input int w, input string tag, output int ocyc);
      rec_t o, e;
      bit   got = 0;
      ocyc = 0;
      for (int k = 0; k < 400 && !got; k++) begin
         if (obs_size(w) > rd[w]) got = 1;
         else @(negedge CLK);
      end
      checks++;
      assert (got) else begin
         failures++;
         $error("FAIL %s_timeout observed=no_done expected=done", tag);
      end
      if (got) begin
         case (w)
            0:       begin o = obs0[rd[0]]; e = exp0.pop_front(); end
            1:       begin o = obs1[rd[1]]; e = exp1.pop_front(); end
            default: begin o = obs2[rd[2]]; e = exp2.pop_front(); end
         endcase
         rd[w]++;
         ocyc = o.cyc;
         chk({tag, "_data"}, 32'(o.data), 32'(e.data));
         chk({tag, "_perr"}, 32'(o.perr), 32'(e.perr));
         chk({tag, "_ferr"}, 32'(o.ferr), 32'(e.ferr));
      end
   endtask

   initial begin
      int t0, tdone;
      logic [8:0] d;

      // reset state
      repeat (3) @(negedge CLK);
      chk("rst_data0", 32'(data0), 0);
      chk("rst_done0", 32'(done0), 0);
      chk("rst_busy0", 32'(busy0), 0);
      chk("rst_errs1", 32'({perr1, ferr1}), 0);
      chk("rst_data2", 32'(data2), 0);
      RSTn = 1'b1;
      repeat (5) @(negedge CLK);

      // 1: 8N1 0xA5 with latency window
      push_exp(0, 9'h0A5, 8, 0, 1'b0, 1'b0);
      t0 = cyc;
      send_frame(0, 9'h0A5, 8, 0, 1'b0, 1);
      hold(0, 1'b1, 2 * C);
      check_out(0, "t1", tdone);
      chk("t1_latency_ok", 32'((tdone - t0) >= 150 && (tdone - t0) <= 160), 1);
      chk("t1_done_count", 32'(obs0.size()), 1);

      // 2: 8E1 wrong parity then correct parity
      push_exp(1, 9'h003, 8, 2, 1'b1, 1'b0);
      send_frame(1, 9'h003, 8, 2, 1'b1, 1);
      push_exp(1, 9'h007, 8, 2, 1'b1, 1'b0);
      send_frame(1, 9'h007, 8, 2, 1'b1, 1);
      hold(1, 1'b1, 2 * C);
      check_out(1, "t2a", tdone);
      check_out(1, "t2b", tdone);

      // 3: 4-clock glitch is rejected as a false start
      hold(0, 1'b0, 4);
      hold(0, 1'b1, 2);
      chk("t3_busy_start", 32'(busy0), 1);
      hold(0, 1'b1, 2 * C);
      chk("t3_busy_idle", 32'(busy0), 0);
      chk("t3_no_done", 32'(obs0.size()), 1);

      // 4: break for 20 bit times, one Done only, then a normal frame
      push_exp(0, 9'h000, 8, 0, 1'b0, 1'b1);
      hold(0, 1'b0, 20 * C);
      chk("t4_busy_break", 32'(busy0), 1);
      check_out(0, "t4", tdone);
      chk("t4_one_done", 32'(obs0.size()), 2);
      hold(0, 1'b1, 2 * C);
      chk("t4_busy_released", 32'(busy0), 0);
      chk("t4_still_one_done", 32'(obs0.size()), 2);
      push_exp(0, 9'h03C, 8, 0, 1'b0, 1'b0);
      send_frame(0, 9'h03C, 8, 0, 1'b0, 1);
      hold(0, 1'b1, 2 * C);
      check_out(0, "t4_after", tdone);

      // 5: 0x55 with a one-clock spike mid bit 3
      d = 9'h055;
      push_exp(0, d, 8, 0, 1'b0, 1'b0);
      hold(0, 1'b0, C);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            hold(0, d[i], 8);
            hold(0, ~d[i], 1);
            hold(0, d[i], 7);
         end else begin
            hold(0, d[i], C);
         end
      end
      hold(0, 1'b1, 3 * C);
      check_out(0, "t5", tdone);

      // 6: 7O2 back-to-back frames, then reset during a third frame
      push_exp(2, 9'h012, 7, 1, good_par(9'h012, 7, 1), 1'b0);
      send_frame(2, 9'h012, 7, 1, good_par(9'h012, 7, 1), 2);
      push_exp(2, 9'h034, 7, 1, good_par(9'h034, 7, 1), 1'b0);
      send_frame(2, 9'h034, 7, 1, good_par(9'h034, 7, 1), 2);
      hold(2, 1'b0, C);
      hold(2, 1'b1, C);
      hold(2, 1'b0, C + 5);
      RSTn = 1'b0;
      pin2 = 1'b1;
      repeat (2) @(negedge CLK);
      chk("t6_rst_done", 32'(done2), 0);
      chk("t6_rst_data", 32'(data2), 0);
      chk("t6_rst_busy", 32'(busy2), 0);
      chk("t6_rst_errs", 32'({perr2, ferr2}), 0);
      RSTn = 1'b1;
      check_out(2, "t6a", tdone);
      check_out(2, "t6b", tdone);
      repeat (12 * C) @(negedge CLK);
      chk("t6_no_third_done", 32'(obs2.size()), 2);
      chk("t6_busy_after", 32'(busy2), 0);
      chk("end_exp_empty", 32'(exp0.size() + exp1.size() + exp2.size()), 0);
      chk("end_no_extra_done0", 32'(obs0.size()), 4);
      chk("end_no_extra_done1", 32'(obs1.size()), 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
